multicycle_main_fsm: RTL

Control state machine for the multi-cycle RV32I core. It replaces the single-cycle opcode decoder: it sequences each instruction through fetch, decode, execute, memory and writeback states and drives the shared-datapath enables and mux selects. It adds parametrised memory wait states, optional JAL/LUI support and illegal-opcode handling. It sits between the instruction register (opcode source) and the multi-cycle datapath (ALU, register file, unified memory).

---
 rtl/multicycle_main_fsm.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// multicycle_main_fsm : control FSM for the multi-cycle RV32I core
// Revision: 1.0
// ============================================================================
module multicycle_main_fsm #(
    parameter int MEM_LATENCY     = 1,
    parameter bit SUPPORT_EXT     = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_ILLEGAL  = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] LAST_CNT   = 4'(MEM_LATENCY - 1);
    localparam state_t     ILL_TARGET = HALT_ON_ILLEGAL ? S_HALT : S_ILLEGAL;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       last_q;
    logic       waiting_q;

    // Moore control word for a state; 'last' marks the final memory wait cycle.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic last);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.ir_write   = last;
                c.pc_update  = last;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = last;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
            end
            S_ILLEGAL, S_HALT: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        last_q    = (cnt_q == LAST_CNT);
        waiting_q = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);
        state_d   = state_q;
        case (state_q)
            S_FETCH:    if (last_q) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = SUPPORT_EXT ? S_JAL : ILL_TARGET;
                    OP_LUI:            state_d = SUPPORT_EXT ? S_LUI : ILL_TARGET;
                    default:           state_d = ILL_TARGET;
                endcase
            end
            // IR is held during decode, so re-sampling the opcode here is safe.
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (last_q) state_d = S_MEMWB;
            S_MEMWRITE: if (last_q) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_ILLEGAL: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        // Counter restarts at zero whenever a wait state is (re)entered.
        cnt_d  = (waiting_q && !last_q) ? cnt_q + 4'd1 : 4'd0;
        ctrl_d = decode_ctrl(state_d, cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
            ctrl_q  <= decode_ctrl(S_FETCH, LAST_CNT == 4'd0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

    // Write strobes are masked while reset is held so an aborted access never commits.
    assign pc_write   = rst_n & (ctrl_q.pc_update | (ctrl_q.branch & zero));
    assign mem_write  = rst_n & ctrl_q.mem_write;
    assign ir_write   = rst_n & ctrl_q.ir_write;
    assign reg_write  = rst_n & ctrl_q.reg_write;
    assign illegal    = rst_n & ctrl_q.illegal;
    assign adr_src    = ctrl_q.adr_src;
    assign result_src = ctrl_q.result_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign fsm_state  = state_q;

endmodule
`default_nettype wire
